// File: rtl/frame_accumulator.sv
// frame_accumulator: sums COUNT signed N-bit samples into one ACC_W-bit frame
// sum and presents it on a valid/ready output port.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  sample handshake, in_data signed N-bit sample
//   out_valid/out_ready frame handshake, out_data signed ACC_W-bit frame sum
//   busy               a frame is in progress (ACC or HOLD)
//
// Build option: define FRAME_ACC_SATURATE_EN to clamp the running sum on
// signed overflow instead of wrapping. Ports, states and timing are unchanged.

// Ripple-carry adder; the carry out of the top bit is not produced.
module ripple_adder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o
);

  logic [N-1:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ carry[i];
    if (i < N - 1) begin : g_carry
      assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

endmodule

module frame_accumulator #(
  parameter int unsigned N     = 10,
  parameter int unsigned ACC_W = 14,
  parameter int unsigned COUNT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [N-1:0]     in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    busy
);

  localparam int unsigned CNT_W = $clog2(COUNT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;

  logic [ACC_W-1:0]  sample_sext;
  logic [ACC_W-1:0]  add_sum;
  logic              in_fire;
  logic              out_fire;

  // Signed operand, so the size cast sign-extends.
  assign sample_sext = ACC_W'(in_data);

  ripple_adder #(.N(ACC_W)) u_adder (
    .a_i   (acc_q),
    .b_i   (sample_sext),
    .cin_i (1'b0),
    .sum_o (add_sum)
  );

  // Next accumulated value for one accepted sample in ACC.
`ifdef FRAME_ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(1) << (ACC_W - 1);
  localparam logic [ACC_W-1:0] SAT_MAX = ~SAT_MIN;

  always_comb begin
    acc_d = add_sum;
    // Overflow: operands share a sign and the sum's sign differs.
    if ((acc_q[ACC_W-1] == sample_sext[ACC_W-1]) &&
        (add_sum[ACC_W-1] != acc_q[ACC_W-1])) begin
      acc_d = acc_q[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  always_comb begin
    acc_d = add_sum;
  end
`endif

  // in_ready resets high for IDLE but must read 0 while rst is held.
  assign in_ready  = in_ready_q & ~rst;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = acc_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready;

  // Frame control FSM with registered handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_fire) begin
            acc_q  <= sample_sext;
            cnt_q  <= CNT_W'(1);
            busy_q <= 1'b1;
            if (COUNT == 1) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ACC;
            end
          end
        end
        ACC: begin
          if (in_fire) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(COUNT - 1)) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_fire) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          acc_q       <= '0;
          cnt_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/frame_accumulator.md
Name: frame_accumulator

Overview:
- Streaming accumulator placed directly downstream of the N-bit sample path.
- Accepts signed N-bit samples over a valid/ready handshake and sums exactly COUNT samples into one frame.
- Each addition uses the team's ripple adder block, parameterised N=ACC_W; the block registers adder result[ACC_W-1:0] as the running sum.
- Presents the frame sum on a valid/ready output port, then clears and starts the next frame.

Parameters:
- N, 10, input sample width (signed two's complement).
- ACC_W, 14, accumulator and output width. Must satisfy ACC_W >= N.
- COUNT, 8, samples per frame. Must satisfy COUNT >= 1.
- CNT_W, $clog2(COUNT+1), sample counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  N  signed input sample.
- out_valid  output  1  out_data holds a completed frame sum.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  ACC_W  signed frame sum.
- busy  output  1  a frame is in progress (state ACC or HOLD).

Behaviour:
- A sample is accepted on a rising clk edge where in_valid && in_ready.
- An output is taken on a rising clk edge where out_valid && out_ready.
- Reset (asynchronous, active-high):
  - Forces state IDLE, acc=0, cnt=0.
  - Outputs during reset: out_valid=0, busy=0, out_data=0. in_ready is forced to 0 while rst is high.
  - Reset mid-frame discards the partial sum; no out_valid follows.
- Sign extension: in_data is sign-extended to ACC_W bits before it reaches the adder. The adder's carry-in is 0.
- States:
  - IDLE: in_ready=1, busy=0. On accept: acc <= sext(in_data), cnt <= 1. Go to HOLD if COUNT==1, else go to ACC.
  - ACC: in_ready=1, busy=1. On accept: acc <= adder(acc, sext(in_data))[ACC_W-1:0], cnt <= cnt+1. Go to HOLD when cnt+1==COUNT. Cycles with no accepted sample leave acc and cnt unchanged.
  - HOLD: in_ready=0, out_valid=1, busy=1. out_data=acc, held stable until the output is taken. On take: acc <= 0, cnt <= 0, go to IDLE.
- Latency and throughput:
  - out_valid rises on the clock edge that accepts the COUNT-th sample, so it is visible in the following cycle.
  - A new frame can start on the cycle after the output is taken.
  - Maximum rate is one frame per COUNT+1 cycles.
- Arithmetic (without SATURATE_EN):
  - ACC_W-bit two's complement with silent wrap-around.
  - The extra adder MSB is ignored.
- Backpressure: in_valid asserted while in HOLD is not accepted. The sample must be held by the upstream stage.
- out_data is driven from the acc register only; there is no combinational path from in_data.

Optional Feature:
- Macro: FRAME_ACC_SATURATE_EN.
- Defined:
  - Each accumulation step checks signed overflow: both operands have the same sign and the sum has a different sign.
  - On positive overflow, acc clamps to 2^(ACC_W-1)-1. On negative overflow, acc clamps to -2^(ACC_W-1).
  - A clamped acc keeps accumulating later samples from the clamped value.
- Undefined: plain wrap-around as described in Behaviour.
- Ports, states and timing are identical in both builds.

Test Plan:
- Defaults; 8 samples 1..8 back-to-back -> out_valid rises one cycle after the 8th accept; out_data=36; busy=1 from the 1st accept until the output is taken.
- Defaults; 8 samples of -512 -> out_data=-4096 (14'h3000). Next frame 8 x 511 -> 4088.
- Defaults; in_valid toggled 1-0-1, samples 3,-5,7,0,0,2,-1,4 -> out_data=10; the frame completes only after 8 accepts.
- Defaults; out_ready held 0 for 5 cycles in HOLD, with in_valid=1 and in_data=9 -> out_data stays 36; in_ready=0; no sample accepted. out_ready=1 -> IDLE next cycle, then 9 is accepted as the first sample of the next frame.
- Reset asserted asynchronously after 4 accepts -> out_valid, busy, in_ready go 0 immediately. After release, 8 samples of 2 -> out_data=16, with no stale sum.
- ACC_W=12; 8 x 511 -> wrap build: out_data=-8; FRAME_ACC_SATURATE_EN build: 2047. 8 x -512 -> wrap build: 0; saturate build: -2048.
